// File: rtl/bpred_table_ctrl.sv
// bpred_table_ctrl: clears the PHT/BTB after reset or flush, then owns the single PHT write port
// Ports: clk_i/rstn_i clock and async active-low reset; flush_req_i restarts the clear walk;
//        upd_* EX-stage branch resolution; cfg_* debug/preload write (valid/ready);
//        pht_* registered PHT write port; btb_clr_* registered BTB invalidate port;
//        pred_en_o/busy_o/clr_done_o walk status; drop_cnt_o updates discarded while clearing.
module bpred_table_ctrl #(
    parameter int          PHT_SIZE = 1024,
    parameter int          BTB_SIZE = 256,
    parameter logic [1:0]  INIT_CNT = 2'b01,
    parameter int          IDX_W    = $clog2(PHT_SIZE),
    parameter int          BIDX_W   = $clog2(BTB_SIZE)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              flush_req_i,
    input  logic              upd_valid_i,
    input  logic [IDX_W-1:0]  upd_idx_i,
    input  logic [1:0]        upd_cnt_i,
    input  logic              upd_taken_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic [1:0]        cfg_data_i,
    output logic              pht_we_o,
    output logic [IDX_W-1:0]  pht_waddr_o,
    output logic [1:0]        pht_wdata_o,
    output logic              btb_clr_we_o,
    output logic [BIDX_W-1:0] btb_clr_addr_o,
    output logic              pred_en_o,
    output logic              busy_o,
    output logic              clr_done_o,
    output logic [15:0]       drop_cnt_o
);
    typedef enum logic {CLEAR, RUN} state_t;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(PHT_SIZE - 1);
    localparam logic [IDX_W:0]   BTB_N = (IDX_W + 1)'(BTB_SIZE);
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  waddr_q, waddr_d;
    logic [1:0]        wdata_q, wdata_d;
    logic              btb_we_q, btb_we_d;
    logic [BIDX_W-1:0] btb_addr_q, btb_addr_d;
    logic              fin_q, fin_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [15:0]       drop_q, drop_d;
    logic              in_btb;
    assign in_btb = {1'b0, ptr_q} < BTB_N;
    assign cfg_ready_o    = (state_q == RUN) & ~upd_valid_i & ~flush_req_i;
    assign pht_we_o       = we_q;
    assign pht_waddr_o    = waddr_q;
    assign pht_wdata_o    = wdata_q;
    assign btb_clr_we_o   = btb_we_q;
    assign btb_clr_addr_o = btb_addr_q;
    assign busy_o         = busy_q;
    assign pred_en_o      = ~busy_q;
    assign clr_done_o     = done_q;
    assign drop_cnt_o     = drop_q;
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        btb_we_d   = 1'b0;
        btb_addr_d = btb_addr_q;
        fin_d      = 1'b0;
        // fin_q marks the cycle the last clear write is on the port; status flips one cycle later
        done_d     = fin_q & ~flush_req_i;
        busy_d     = flush_req_i | (busy_q & ~fin_q);
        drop_d     = (upd_valid_i & (state_q == CLEAR | flush_req_i) & drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        if (flush_req_i) begin
            state_d = CLEAR;
            ptr_d   = '0;
        end else if (state_q == CLEAR) begin
            we_d       = 1'b1;
            waddr_d    = ptr_q;
            wdata_d    = INIT_CNT;
            btb_we_d   = in_btb;
            btb_addr_d = in_btb ? ptr_q[BIDX_W-1:0] : btb_addr_q;
            ptr_d      = ptr_q + 1'b1;
            state_d    = (ptr_q == LAST) ? RUN : CLEAR;
            fin_d      = ptr_q == LAST;
        end else if (upd_valid_i) begin
            we_d    = 1'b1;
            waddr_d = upd_idx_i;
            wdata_d = upd_taken_i ? ((upd_cnt_i == 2'b11) ? 2'b11 : upd_cnt_i + 2'b01)
                                  : ((upd_cnt_i == 2'b00) ? 2'b00 : upd_cnt_i - 2'b01);
        end else if (cfg_valid_i) begin
            we_d    = 1'b1;
            waddr_d = cfg_idx_i;
            wdata_d = cfg_data_i;
        end
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= CLEAR;
            ptr_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            btb_we_q   <= 1'b0;
            btb_addr_q <= '0;
            fin_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            btb_we_q   <= btb_we_d;
            btb_addr_q <= btb_addr_d;
            fin_q      <= fin_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end
endmodule

// File: tb/tb_bpred_table_ctrl.sv
// tb_bpred_table_ctrl: scoreboard bench for bpred_table_ctrl with a cycle-level reference model
module tb_bpred_table_ctrl;
    localparam int PS = 16;
    localparam int BS = 8;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       flush = 1'b0, upd_v = 1'b0, upd_t = 1'b0, cfg_v = 1'b0;
    logic [3:0] upd_idx = '0, cfg_idx = '0;
    logic [1:0] upd_cnt = '0, cfg_dat = '0;
    logic       cfg_ready, pht_we, btb_we, pred_en, busy, done;
    logic [3:0] pht_waddr;
    logic [1:0] pht_wdata;
    logic [2:0] btb_addr;
    logic [15:0] drop_cnt;
    always #5 clk = ~clk;
    bpred_table_ctrl #(.PHT_SIZE(PS), .BTB_SIZE(BS), .INIT_CNT(2'b01)) dut (
        .clk_i(clk), .rstn_i(rstn), .flush_req_i(flush),
        .upd_valid_i(upd_v), .upd_idx_i(upd_idx), .upd_cnt_i(upd_cnt), .upd_taken_i(upd_t),
        .cfg_valid_i(cfg_v), .cfg_ready_o(cfg_ready), .cfg_idx_i(cfg_idx), .cfg_data_i(cfg_dat),
        .pht_we_o(pht_we), .pht_waddr_o(pht_waddr), .pht_wdata_o(pht_wdata),
        .btb_clr_we_o(btb_we), .btb_clr_addr_o(btb_addr),
        .pred_en_o(pred_en), .busy_o(busy), .clr_done_o(done), .drop_cnt_o(drop_cnt)
    );
    typedef struct packed {logic [3:0] a; logic [1:0] d;} wr_t;
    wr_t pq[$];
    int  bq[$];
    bit  m_clear, m_pend, e_done, e_busy;
    int  m_ptr, m_drop;
    int  errors = 0, checks = 0, done_seen = 0;
    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask
    function automatic void mreset();
        m_clear = 1; m_pend = 0; e_done = 0; e_busy = 1; m_ptr = 0; m_drop = 0;
        pq.delete(); bq.delete();
    endfunction
    function automatic int nxt(input int c, input bit t);
        return t ? (c < 3 ? c + 1 : 3) : (c > 0 ? c - 1 : 0);
    endfunction
    // Reference model: what each edge should put on the outputs seen at the next negedge
    always @(posedge clk) begin
        if (!rstn) mreset();
        else begin
            e_done = m_pend && !flush;
            m_pend = 0;
            if ((flush || m_clear) && upd_v) m_drop = (m_drop < 65535) ? m_drop + 1 : m_drop;
            if (flush) begin
                m_clear = 1; m_ptr = 0; e_busy = 1;
            end else if (m_clear) begin
                pq.push_back('{a: 4'(m_ptr), d: 2'b01});
                if (m_ptr < BS) bq.push_back(m_ptr);
                if (m_ptr == PS - 1) begin m_clear = 0; m_pend = 1; end
                m_ptr++;
            end else if (upd_v) pq.push_back('{a: upd_idx, d: 2'(nxt(int'(upd_cnt), upd_t))});
            else if (cfg_v) pq.push_back('{a: cfg_idx, d: cfg_dat});
            if (e_done) e_busy = 0;
        end
    end
    always @(negedge clk) begin
        wr_t w;
        if (pht_we) begin
            if (pq.size() == 0) chk("pht_extra_write", 1, 0);
            else begin
                w = pq.pop_front();
                chk("pht_addr", int'(pht_waddr), int'(w.a));
                chk("pht_data", int'(pht_wdata), int'(w.d));
            end
        end
        if (pq.size() != 0) begin chk("pht_missing_write", pq.size(), 0); pq.delete(); end
        if (btb_we) begin
            if (bq.size() == 0) chk("btb_extra_clear", 1, 0);
            else chk("btb_addr", int'(btb_addr), bq.pop_front());
        end
        if (bq.size() != 0) begin chk("btb_missing_clear", bq.size(), 0); bq.delete(); end
        chk("clr_done", int'(done), int'(e_done));
        chk("busy", int'(busy), int'(e_busy));
        chk("pred_en", int'(pred_en), int'(!e_busy));
        chk("drop_cnt", int'(drop_cnt), m_drop);
        if (done) done_seen++;
    end
    task automatic step(input bit f, input bit u, input int ui, input int uc, input bit ut,
                        input bit cv, input int ci, input int cd);
        @(negedge clk);
        flush = f; upd_v = u; upd_idx = 4'(ui); upd_cnt = 2'(uc); upd_t = ut;
        cfg_v = cv; cfg_idx = 4'(ci); cfg_dat = 2'(cd);
        #1 chk("cfg_ready", int'(cfg_ready), int'(!m_clear && !u && !f));
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic rst_chk(input string n);
        chk({n, "_we"}, int'(pht_we), 0);
        chk({n, "_waddr"}, int'(pht_waddr), 0);
        chk({n, "_wdata"}, int'(pht_wdata), 0);
        chk({n, "_btb_we"}, int'(btb_we), 0);
        chk({n, "_btb_addr"}, int'(btb_addr), 0);
        chk({n, "_pred_en"}, int'(pred_en), 0);
        chk({n, "_busy"}, int'(busy), 1);
        chk({n, "_done"}, int'(done), 0);
        chk({n, "_drop"}, int'(drop_cnt), 0);
        chk({n, "_cfg_ready"}, int'(cfg_ready), 0);
    endtask
    initial begin
        bit f, u, t, cv, acc;
        int ci, cd, base;
        mreset();
        #12 rst_chk("reset");
        @(negedge clk); rstn = 1;
        for (int i = 0; i < 3; i++) step(0, 1, i + 2, 3, 1, 0, 0, 0);
        idle(16);
        chk("drop_after_walk", int'(drop_cnt), 3);
        chk("done_after_walk", done_seen, 1);
        step(0, 1, 5, 2, 1, 0, 0, 0);
        step(0, 1, 5, 3, 1, 0, 0, 0);
        step(0, 1, 5, 0, 0, 0, 0, 0);
        step(0, 1, 5, 1, 0, 0, 0, 0);
        step(0, 1, 7, 1, 1, 1, 3, 2);
        step(0, 0, 0, 0, 0, 1, 3, 2);
        idle(2);
        base = done_seen;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        step(1, 1, 4, 2, 0, 1, 6, 3);
        idle(20);
        chk("done_once_after_restart", done_seen - base, 1);
        cv = 0; ci = 0; cd = 0;
        for (int i = 0; i < 400; i++) begin
            f = ($urandom % 40) == 0;
            u = $urandom % 2;
            t = $urandom % 2;
            if (!cv) begin cv = $urandom % 2; ci = $urandom % PS; cd = $urandom % 4; end
            step(f, u, $urandom % PS, $urandom % 4, t, cv, ci, cd);
            acc = cv && !u && !f && !m_clear;
            if (acc) cv = 0;
        end
        idle(20);
        step(0, 1, 9, 1, 1, 0, 0, 0);
        @(posedge clk); #2;
        chk("pre_reset_we", int'(pht_we), 1);
        rstn = 0;
        mreset();
        #1 rst_chk("async_reset");
        base = done_seen;
        @(negedge clk); rstn = 1;
        idle(20);
        chk("done_after_rerun", done_seen - base, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bpred_table_ctrl.md
Name: bpred_table_ctrl

Overview:
Maintenance and write-port controller for the bimodal predictor's PHT and BTB storage. After reset and on every flush request, it walks the tables and clears them: each PHT entry is written to INIT_CNT and each BTB entry is invalidated. While the walk runs, it holds prediction disabled. In normal operation it computes saturating 2-bit counter updates from EX-stage branch resolution and arbitrates the single PHT write port between those updates and a debug/preload config port.

Parameters:
PHT_SIZE, 1024, PHT entries; power of two; must be >= BTB_SIZE.
BTB_SIZE, 256, BTB entries; power of two.
INIT_CNT, 2'b01, counter value written during clear (weakly not-taken).
IDX_W, $clog2(PHT_SIZE), PHT index width (derived).
BIDX_W, $clog2(BTB_SIZE), BTB index width (derived).

Ports:
clk_i  in  1  clock, rising edge.
rstn_i  in  1  asynchronous active-low reset.
flush_req_i  in  1  level or pulse; a 1 sampled at a rising edge starts or restarts the clear walk.
upd_valid_i  in  1  EX-stage resolved branch/jump this cycle.
upd_idx_i  in  IDX_W  PHT index of the resolved branch.
upd_cnt_i  in  2  current PHT counter value read at upd_idx_i.
upd_taken_i  in  1  branch resolved taken.
cfg_valid_i  in  1  config write request.
cfg_ready_o  out  1  config write accepted this cycle (valid & ready = accept).
cfg_idx_i  in  IDX_W  config target index.
cfg_data_i  in  2  config counter value.
pht_we_o  out  1  PHT write enable (registered).
pht_waddr_o  out  IDX_W  PHT write index (registered).
pht_wdata_o  out  2  PHT write data (registered).
btb_clr_we_o  out  1  BTB entry invalidate enable (registered).
btb_clr_addr_o  out  BIDX_W  BTB index to invalidate (registered).
pred_en_o  out  1  predictions may be used; fetch treats prediction as not-taken when 0.
busy_o  out  1  clear walk in progress.
clr_done_o  out  1  one-cycle pulse after the final clear write.
drop_cnt_o  out  16  saturating count of updates dropped during clear.

Behaviour:
- Reset (async): state=CLEAR, ptr=0, pht_we_o=0, pht_waddr_o=0, pht_wdata_o=0, btb_clr_we_o=0, btb_clr_addr_o=0, pred_en_o=0, busy_o=1, clr_done_o=0, drop_cnt_o=0, cfg_ready_o=0. The walk begins on the first edge after reset deassertion.
- States: CLEAR, RUN.
- CLEAR, each cycle:
  - Registered outputs: pht_we_o=1, pht_waddr_o=ptr, pht_wdata_o=INIT_CNT.
  - btb_clr_we_o=1 with btb_clr_addr_o=ptr[BIDX_W-1:0] only while ptr < BTB_SIZE; otherwise btb_clr_we_o=0.
  - ptr increments by 1. The walk takes exactly PHT_SIZE cycles of writes.
  - On the write with ptr=PHT_SIZE-1, the next state is RUN. On the following cycle clr_done_o=1 for one cycle, busy_o=0 and pred_en_o=1.
- CLEAR with upd_valid_i=1: the update is discarded and drop_cnt_o increments, saturating at 16'hFFFF.
- CLEAR: cfg_ready_o=0.
- RUN, priority flush > upd > cfg:
  - flush_req_i=1: ptr=0, state=CLEAR, busy_o=1 and pred_en_o=0 from the next cycle. A simultaneous upd/cfg is not written. The upd is counted as dropped; the cfg is not accepted (cfg_ready_o=0).
  - upd_valid_i=1: next cycle pht_we_o=1, pht_waddr_o=upd_idx_i, pht_wdata_o = (upd_taken_i ? sat_inc(upd_cnt_i) : sat_dec(upd_cnt_i)).
    - 2'b11 stays 2'b11 on taken; 2'b00 stays 2'b00 on not-taken.
    - The write happens even when the value is unchanged.
  - Else cfg_valid_i=1: cfg_ready_o=1 combinationally this cycle; next cycle pht_we_o=1, pht_waddr_o=cfg_idx_i, pht_wdata_o=cfg_data_i.
  - cfg_ready_o = (state==RUN) & !upd_valid_i & !flush_req_i. A pending cfg request waits, holding stable, until accepted.
  - Otherwise pht_we_o=0. pht_waddr_o and pht_wdata_o hold their last values.
- btb_clr_we_o is 0 in RUN. BTB target/tag writes stay in the predictor itself.
- flush_req_i=1 during CLEAR restarts the walk at ptr=0. Completion is delayed accordingly, and clr_done_o pulses only once, at the final completion.
- Write latency is exactly 1 cycle from request to pht_we_o, for all sources.
- drop_cnt_o is cleared only by reset.

Test Plan:
- PHT_SIZE=16, BTB_SIZE=8: release reset -> pht_we_o=1 for 16 consecutive cycles with addr 0..15 and data 2'b01; btb_clr_we_o=1 with addr 0..7 in the first 8 of those cycles, then 0; clr_done_o pulses once; pred_en_o rises the same cycle and busy_o falls.
- RUN, upd (idx=5, cnt=2'b10, taken=1) -> next cycle write idx 5 data 2'b11; then (cnt=2'b11, taken=1) -> data 2'b11; (cnt=2'b00, taken=0) -> data 2'b00; (cnt=2'b01, taken=0) -> data 2'b00.
- RUN, cfg_valid_i=1 (idx=3, data=2'b10) together with upd_valid_i=1 (idx=7) -> cfg_ready_o=0 and idx 7 is written; next cycle with upd_valid_i=0 -> cfg_ready_o=1 and idx 3 is written with 2'b10 one cycle later.
- Three updates during the initial clear -> no update writes occur; drop_cnt_o=3 after the walk.
- flush_req_i at walk ptr=10 -> ptr restarts at 0; 16 further writes follow; clr_done_o pulses exactly once in total.
- Assert rstn_i low mid-RUN with pht_we_o=1 -> all outputs take reset values immediately (asynchronously); the walk restarts from idx 0 after release.
